universal_shift_register: RTL and testbench

UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

---
 rtl/universal_shift_register.sv | 154 +++++++++++++++
 tb/tb_universal_shift_register.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/universal_shift_register.sv
// -----------------------------------------------------------------------------
// universal_shift_register
//
// Purpose:
//   WIDTH-bit universal shift register with hold, shift left/right, parallel
//   load, arithmetic shift right and optional rotate modes.
//   A burst engine applies one shift/rotate mode a programmed number of times
//   with a single START request.
//
// Configuration:
//   USR_ROTATE_EN - when defined, codes 100/101 rotate toward MSB/LSB.
//                   When undefined, these codes hold Q, and a burst started
//                   with them completes at once as a zero-length burst.
//
// Ports:
//   CP     in   1      rising-edge clock
//   CR     in   1      asynchronous active-low reset
//   EN     in   1      clock enable, 0 freezes all state
//   S      in   3      mode select
//   D      in   WIDTH  parallel load data
//   DSR    in   1      serial-in at bit 0 (shift toward MSB)
//   DSL    in   1      serial-in at bit WIDTH-1 (shift toward LSB)
//   START  in   1      burst request
//   N      in   CNT_W  burst shift count
//   Q      out  WIDTH  register contents
//   SOR    out  1      Q[WIDTH-1]
//   SOL    out  1      Q[0]
//   BUSY   out  1      burst in progress
//   DONE   out  1      one-cycle burst-complete pulse
// -----------------------------------------------------------------------------
module universal_shift_register #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             CP,
    input  logic             CR,
    input  logic             EN,
    input  logic [2:0]       S,
    input  logic [WIDTH-1:0] D,
    input  logic             DSR,
    input  logic             DSL,
    input  logic             START,
    input  logic [CNT_W-1:0] N,
    output logic [WIDTH-1:0] Q,
    output logic             SOR,
    output logic             SOL,
    output logic             BUSY,
    output logic             DONE
);

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e           r_state;
    logic [WIDTH-1:0] r_q;
    logic [2:0]       r_mode;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_q_live;
    logic [WIDTH-1:0] w_q_burst;
    logic             w_burst_ok;

    // Next Q value for a given mode; unsupported codes hold.
    function automatic logic [WIDTH-1:0] f_next_q(
        input logic [2:0]       mode,
        input logic [WIDTH-1:0] q,
        input logic [WIDTH-1:0] d,
        input logic             dsr,
        input logic             dsl
    );
        logic [WIDTH-1:0] res;
        res = q;
        case (mode)
            3'b001:  res = {q[WIDTH-2:0], dsr};
            3'b010:  res = {dsl, q[WIDTH-1:1]};
            3'b011:  res = d;
`ifdef USR_ROTATE_EN
            3'b100:  res = {q[WIDTH-2:0], q[WIDTH-1]};
            3'b101:  res = {q[0], q[WIDTH-1:1]};
`endif
            3'b110:  res = {q[WIDTH-1], q[WIDTH-1:1]};
            default: res = q;
        endcase
        return res;
    endfunction

    // Codes that make a real burst; anything else completes immediately.
    function automatic logic f_is_burst_mode(input logic [2:0] mode);
        logic ok;
        case (mode)
            3'b001, 3'b010, 3'b110: ok = 1'b1;
`ifdef USR_ROTATE_EN
            3'b100, 3'b101:         ok = 1'b1;
`endif
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign w_q_live   = f_next_q(S, r_q, D, DSR, DSL);
    assign w_q_burst  = f_next_q(r_mode, r_q, D, DSR, DSL);
    assign w_burst_ok = f_is_burst_mode(S) && (N != '0);

    always_ff @(posedge CP or negedge CR) begin
        if (!CR) begin
            r_state <= StIdle;
            r_q     <= '0;
            r_mode  <= 3'b000;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (EN) begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (START) begin
                        // Capture edge: Q untouched, mode/count latched.
                        r_mode <= S;
                        r_cnt  <= N;
                        if (w_burst_ok) begin
                            r_state <= StBurst;
                            r_busy  <= 1'b1;
                        end else begin
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_q <= w_q_live;
                    end
                end
                StBurst: begin
                    r_q   <= w_q_burst;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign Q    = r_q;
    assign SOR  = r_q[WIDTH-1];
    assign SOL  = r_q[0];
    assign BUSY = r_busy;
    assign DONE = r_done;

endmodule

// File: tb/tb_universal_shift_register.sv
module tb_universal_shift_register;

    logic       CP;
    logic       CR;
    logic       EN;
    logic [2:0] S;
    logic [7:0] D;
    logic       DSR;
    logic       DSL;
    logic       START;
    logic [3:0] N;
    logic [7:0] Q;
    logic       SOR;
    logic       SOL;
    logic       BUSY;
    logic       DONE;

    int n_cmp;
    int n_fail;

    universal_shift_register #(.WIDTH(8)) dut (
        .CP    (CP),
        .CR    (CR),
        .EN    (EN),
        .S     (S),
        .D     (D),
        .DSR   (DSR),
        .DSL   (DSL),
        .START (START),
        .N     (N),
        .Q     (Q),
        .SOR   (SOR),
        .SOL   (SOL),
        .BUSY  (BUSY),
        .DONE  (DONE)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge CP);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [7:0] q,
                               input logic busy, input logic done);
        check({tag, ".Q"}, 32'(Q), 32'(q));
        check({tag, ".BUSY"}, 32'(BUSY), 32'(busy));
        check({tag, ".DONE"}, 32'(DONE), 32'(done));
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        CR = 1'b0; EN = 1'b0; S = 3'b000; D = 8'h00;
        DSR = 1'b0; DSL = 1'b0; START = 1'b0; N = 4'd0;

        // Reset state
        #3;
        check_state("reset", 8'h00, 1'b0, 1'b0);
        tick();
        CR = 1'b1;
        EN = 1'b1;

        // Parallel load
        S = 3'b011; D = 8'hA5;
        tick();
        check("load.Q", 32'(Q), 32'h A5);
        check("load.SOR", 32'(SOR), 32'd1);
        check("load.SOL", 32'(SOL), 32'd1);

        // Shift toward MSB then toward LSB
        S = 3'b001; DSR = 1'b1;
        tick();
        check("shl.Q", 32'(Q), 32'h4B);
        S = 3'b010; DSL = 1'b0;
        tick();
        check("shr.Q", 32'(Q), 32'h25);
        check("shr.SOR", 32'(SOR), 32'd0);

        // Arithmetic shift right x3
        S = 3'b011; D = 8'h80;
        tick();
        S = 3'b110;
        tick();
        check("asr1.Q", 32'(Q), 32'hC0);
        tick();
        tick();
        check("asr3.Q", 32'(Q), 32'hF0);

        // Hold codes
        S = 3'b000;
        tick();
        check("hold000.Q", 32'(Q), 32'hF0);
        S = 3'b111;
        tick();
        check("hold111.Q", 32'(Q), 32'hF0);

        // EN=0 freezes a load
        EN = 1'b0; S = 3'b011; D = 8'h00;
        tick();
        check("en0.Q", 32'(Q), 32'hF0);
        EN = 1'b1;

        // Burst of 4 left shifts with a 2-cycle EN pause
        D = 8'h01;
        tick();
        START = 1'b1; S = 3'b001; N = 4'd4; DSR = 1'b0;
        tick();
        check_state("bst.cap", 8'h01, 1'b1, 1'b0);
        START = 1'b0; S = 3'b011; D = 8'hFF;
        tick();
        check_state("bst.1", 8'h02, 1'b1, 1'b0);
        START = 1'b1; N = 4'd1;           // ignored while busy
        tick();
        check_state("bst.2", 8'h04, 1'b1, 1'b0);
        START = 1'b0;
        EN = 1'b0;
        tick();
        check_state("bst.p1", 8'h04, 1'b1, 1'b0);
        tick();
        check_state("bst.p2", 8'h04, 1'b1, 1'b0);
        EN = 1'b1;
        tick();
        check_state("bst.3", 8'h08, 1'b1, 1'b0);
        tick();
        check_state("bst.4", 8'h10, 1'b0, 1'b1);
        S = 3'b000;
        tick();
        check_state("bst.end", 8'h10, 1'b0, 1'b0);

        // Reset mid-burst aborts with no DONE
        START = 1'b1; S = 3'b001; N = 4'd5; DSR = 1'b1;
        tick();
        START = 1'b0; S = 3'b000;
        tick();
        check_state("rb.1", 8'h21, 1'b1, 1'b0);
        #2;
        CR = 1'b0;
        #1;
        check_state("rb.rst", 8'h00, 1'b0, 1'b0);
        tick();
        CR = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_state("rb.after", 8'h00, 1'b0, 1'b0);
        end

        // Zero-length bursts
        S = 3'b011; D = 8'h3C;
        tick();
        START = 1'b1; S = 3'b001; N = 4'd0;
        tick();
        check_state("zl.n0", 8'h3C, 1'b0, 1'b1);
        START = 1'b0; S = 3'b000;
        tick();
        check_state("zl.n0end", 8'h3C, 1'b0, 1'b0);
        START = 1'b1; S = 3'b011; N = 4'd3; D = 8'hFF;
        tick();
        check_state("zl.load", 8'h3C, 1'b0, 1'b1);
        START = 1'b0; S = 3'b000;
        tick();
        check_state("zl.loadend", 8'h3C, 1'b0, 1'b0);

        // Rotate modes
        S = 3'b011; D = 8'h81;
        tick();
`ifdef USR_ROTATE_EN
        START = 1'b1; S = 3'b100; N = 4'd3;
        tick();
        check_state("rot.cap", 8'h81, 1'b1, 1'b0);
        START = 1'b0; S = 3'b101;         // ignored during the burst
        tick();
        check_state("rot.1", 8'h03, 1'b1, 1'b0);
        tick();
        check_state("rot.2", 8'h06, 1'b1, 1'b0);
        tick();
        check_state("rot.3", 8'h0C, 1'b0, 1'b1);
        S = 3'b000;
        tick();
        check_state("rot.end", 8'h0C, 1'b0, 1'b0);
        S = 3'b101;
        tick();
        check("rotr.Q", 32'(Q), 32'h06);
`else
        S = 3'b100;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("norot100.Q", 32'(Q), 32'h81);
        end
        S = 3'b101;
        tick();
        check("norot101.Q", 32'(Q), 32'h81);
        START = 1'b1; S = 3'b100; N = 4'd2;
        tick();
        check_state("norot.start", 8'h81, 1'b0, 1'b1);
        START = 1'b0; S = 3'b000;
        tick();
        check_state("norot.end", 8'h81, 1'b0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
